mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 128-bit block-wide data memory (28-bit block address, READ/WRITE/BUSYWAIT handshake). Sits between the instruction-cache miss port (read-only) and the data-cache miss/writeback port (read/write) and the single memory instance. Grants one access at a time with round-robin fairness, latches the winner's command, holds memory strobes until completion and returns read data with a one-cycle completion pulse to the winner.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data cache to block-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AddrWidth  = 28;
  localparam int unsigned BlockWidth = 128;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StMemI  = 3'd1,
    StMemD  = 3'd2,
    StDoneI = 3'd3,
    StDoneD = 3'd4
  } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache read port and the D-cache read/write port
// for a single block-wide memory; sequences one latched access at a time.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [AddrWidth-1:0]  I_ADDRESS,
  output logic [BlockWidth-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [AddrWidth-1:0]  D_ADDRESS,
  input  logic [BlockWidth-1:0] D_WRITEDATA,
  output logic [BlockWidth-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [AddrWidth-1:0]  MEM_ADDRESS,
  output logic [BlockWidth-1:0] MEM_WRITEDATA,
  input  logic [BlockWidth-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_last;
  logic                  r_first;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [AddrWidth-1:0]  r_addr;
  logic [BlockWidth-1:0] r_wdata;
  logic [BlockWidth-1:0] r_rdata_i;
  logic [BlockWidth-1:0] r_rdata_d;

  logic w_req_i;
  logic w_req_d;
  logic w_grant;
  logic w_grant_port;
  logic w_complete;

  assign w_req_i = I_READ;
  assign w_req_d = D_READ | D_WRITE;

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_port = PORT_I;
    w_complete   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req_i || w_req_d) begin
          w_grant = 1'b1;
          // On a tie the port that was not served last wins.
          if (w_req_i && w_req_d) begin
            w_grant_port = (r_last == PORT_I) ? PORT_D : PORT_I;
          end else begin
            w_grant_port = w_req_d ? PORT_D : PORT_I;
          end
          w_state_next = (w_grant_port == PORT_D) ? StMemD : StMemI;
        end
      end
      StMemI, StMemD: begin
        // The memory's busy flag is not trusted on the edge right after strobing.
        if (!r_first && !MEM_BUSYWAIT) begin
          w_complete   = 1'b1;
          w_state_next = (r_state == StMemD) ? StDoneD : StDoneI;
        end
      end
      StDoneI, StDoneD: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= StIdle;
      r_last      <= PORT_I;
      r_first     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata_i   <= '0;
      r_rdata_d   <= '0;
    end else begin
      r_state <= w_state_next;
      r_first <= w_grant;
      if (w_grant) begin
        if (w_grant_port == PORT_D) begin
          r_addr      <= D_ADDRESS;
          r_wdata     <= D_WRITEDATA;
          // A simultaneous read and write request is serviced as a write.
          r_mem_write <= D_WRITE;
          r_mem_read  <= ~D_WRITE;
        end else begin
          r_addr      <= I_ADDRESS;
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b1;
        end
      end
      if (w_complete) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_last      <= (r_state == StMemD) ? PORT_D : PORT_I;
        if (r_mem_read) begin
          if (r_state == StMemD) begin
            r_rdata_d <= MEM_READDATA;
          end else begin
            r_rdata_i <= MEM_READDATA;
          end
        end
      end
    end
  end

  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_addr;
  assign MEM_WRITEDATA = r_wdata;
  assign I_READDATA    = r_rdata_i;
  assign D_READDATA    = r_rdata_d;
  assign I_BUSYWAIT    = w_req_i && (r_state != StDoneI);
  assign D_BUSYWAIT    = w_req_d && (r_state != StDoneD);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, a small block memory with
// programmable latency, directed scenarios and a randomized two-requester phase.
module tb_mem_arbiter;

  logic         CLK;
  logic         RESET;
  logic         I_READ;
  logic [27:0]  I_ADDRESS;
  logic [127:0] I_READDATA;
  logic         I_BUSYWAIT;
  logic         D_READ;
  logic         D_WRITE;
  logic [27:0]  D_ADDRESS;
  logic [127:0] D_WRITEDATA;
  logic [127:0] D_READDATA;
  logic         D_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .I_READ       (I_READ),
    .I_ADDRESS    (I_ADDRESS),
    .I_READDATA   (I_READDATA),
    .I_BUSYWAIT   (I_BUSYWAIT),
    .D_READ       (D_READ),
    .D_WRITE      (D_WRITE),
    .D_ADDRESS    (D_ADDRESS),
    .D_WRITEDATA  (D_WRITEDATA),
    .D_READDATA   (D_READDATA),
    .D_BUSYWAIT   (D_BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [127:0] preload(input logic [3:0] idx);
    return {4{32'hA5A5_0000 | {24'h0, idx, 4'h0}}};
  endfunction

  task automatic chk_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Block memory: addresses used by this bench differ only in bits [7:4].
  int           mem_lat = 0;
  int           memcnt;
  bit           mem_vld [16];
  logic [127:0] mem_dat [16];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) memcnt <= 0;
    else if (MEM_READ || MEM_WRITE) memcnt <= memcnt + 1;
    else memcnt <= 0;
  end

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (memcnt < mem_lat + 1);
  assign MEM_READDATA = mem_vld[MEM_ADDRESS[7:4]] ? mem_dat[MEM_ADDRESS[7:4]]
                                                   : preload(MEM_ADDRESS[7:4]);

  always @(posedge CLK) begin
    if (!RESET && MEM_WRITE && !MEM_BUSYWAIT) begin
      mem_vld[MEM_ADDRESS[7:4]] <= 1'b1;
      mem_dat[MEM_ADDRESS[7:4]] <= MEM_WRITEDATA;
    end
  end

  // Reference model: owner of the current access (-1 none), port in its done cycle,
  // edges since grant, and the expected memory image built from requester data.
  int           m_owner = -1;
  int           m_done  = -1;
  int           m_age   = 0;
  int           m_last  = 0;
  bit           m_wr    = 1'b0;
  logic [27:0]  m_addr  = '0;
  logic [127:0] m_wdata = '0;
  logic [127:0] m_rd [2];
  bit           sh_vld [16];
  logic [127:0] sh_dat [16];
  int           rd_hi = 0;
  int           wr_hi = 0;

  initial forever begin
    @(negedge CLK);
    if (RESET) begin
      m_owner = -1;
      m_done  = -1;
      m_age   = 0;
      m_last  = 0;
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else begin
      chk_b("mem_read", MEM_READ, (m_owner >= 0) && !m_wr);
      chk_b("mem_write", MEM_WRITE, (m_owner >= 0) && m_wr);
      if (m_owner >= 0) chk_i("mem_address", int'(MEM_ADDRESS), int'(m_addr));
      if (m_owner >= 0 && m_wr) chk_w("mem_writedata", MEM_WRITEDATA, m_wdata);
      chk_b("i_busywait", I_BUSYWAIT, I_READ && (m_done != 0));
      chk_b("d_busywait", D_BUSYWAIT, (D_READ || D_WRITE) && (m_done != 1));
      chk_w("i_readdata", I_READDATA, m_rd[0]);
      chk_w("d_readdata", D_READDATA, m_rd[1]);
      if (MEM_READ) rd_hi++;
      if (MEM_WRITE) wr_hi++;
      // Advance the model across the coming rising edge.
      if (m_done >= 0) begin
        m_done = -1;
      end else if (m_owner >= 0) begin
        m_age++;
        if (m_age >= 2 && !MEM_BUSYWAIT) begin
          if (m_wr) begin
            sh_vld[m_addr[7:4]] = 1'b1;
            sh_dat[m_addr[7:4]] = m_wdata;
          end else begin
            m_rd[m_owner] = sh_vld[m_addr[7:4]] ? sh_dat[m_addr[7:4]] : preload(m_addr[7:4]);
          end
          m_last  = m_owner;
          m_done  = m_owner;
          m_owner = -1;
        end
      end else if (I_READ || D_READ || D_WRITE) begin
        if (I_READ && (D_READ || D_WRITE)) m_owner = (m_last == 0) ? 1 : 0;
        else m_owner = I_READ ? 0 : 1;
        m_wr    = (m_owner == 1) && D_WRITE;
        m_addr  = (m_owner == 1) ? D_ADDRESS : I_ADDRESS;
        m_wdata = D_WRITEDATA;
        m_age   = 0;
      end
    end
  end

  bit tog_en = 1'b0;
  initial forever begin
    @(posedge CLK);
    #1;
    if (tog_en) D_ADDRESS = D_ADDRESS ^ 28'h40;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input bit port_d, output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge CLK);
      if (port_d ? !D_BUSYWAIT : !I_BUSYWAIT) break;
      cyc++;
    end
    if (cyc >= 100) chk_i("wait_done_timeout", cyc, 0);
    @(posedge CLK);
    #2;
    if (port_d) begin
      D_READ  = 1'b0;
      D_WRITE = 1'b0;
    end else begin
      I_READ = 1'b0;
    end
  endtask

  task automatic tie_round(input logic [27:0] ai, input logic [27:0] ad);
    int cyc;
    bit first_d;
    first_d   = 1'b0;
    cyc       = 0;
    I_ADDRESS = ai;
    D_ADDRESS = ad;
    I_READ    = 1'b1;
    D_READ    = 1'b1;
    while (cyc < 100) begin
      @(negedge CLK);
      if (!D_BUSYWAIT) begin
        first_d = 1'b1;
        break;
      end
      if (!I_BUSYWAIT) break;
      cyc++;
    end
    if (cyc >= 100) chk_i("tie_timeout", cyc, 0);
    chk_b("tie_winner_is_d", first_d, 1'b1);
    @(posedge CLK);
    #2;
    if (first_d) D_READ = 1'b0;
    else I_READ = 1'b0;
    wait_done(!first_d, cyc);
  endtask

  int  cyc;
  bit  acc_i;
  bit  acc_d;
  int  op;

  initial begin
    RESET       = 1'b1;
    I_READ      = 1'b0;
    I_ADDRESS   = '0;
    D_READ      = 1'b0;
    D_WRITE     = 1'b0;
    D_ADDRESS   = '0;
    D_WRITEDATA = '0;
    repeat (3) @(posedge CLK);
    #2;
    RESET = 1'b0;
    @(negedge CLK);
    chk_b("rst_mem_read", MEM_READ, 1'b0);
    chk_b("rst_mem_write", MEM_WRITE, 1'b0);
    chk_i("rst_mem_address", int'(MEM_ADDRESS), 0);
    chk_w("rst_mem_writedata", MEM_WRITEDATA, '0);
    chk_w("rst_i_readdata", I_READDATA, '0);
    chk_b("rst_i_busywait", I_BUSYWAIT, 1'b0);
    @(posedge CLK);
    #2;

    // Single I-port read, memory ready at first opportunity.
    I_ADDRESS = 28'h0000010;
    I_READ    = 1'b1;
    rd_hi     = 0;
    wait_done(1'b0, cyc);
    chk_i("i_read_busy_edges", cyc, 3);
    chk_i("i_read_strobe_cycles", rd_hi, 2);
    chk_w("i_read_data", I_READDATA, {4{32'hA5A50010}});

    // D write then read-back of the same block.
    D_ADDRESS   = 28'h0000020;
    D_WRITEDATA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    D_WRITE     = 1'b1;
    rd_hi       = 0;
    wr_hi       = 0;
    wait_done(1'b1, cyc);
    chk_i("d_write_strobe_cycles", wr_hi, 2);
    chk_i("d_write_no_read", rd_hi, 0);
    D_READ = 1'b1;
    wait_done(1'b1, cyc);
    chk_w("d_readback", D_READDATA, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

    // Fairness from a fresh reset.
    RESET = 1'b1;
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    for (int r = 0; r < 4; r++) begin
      tie_round(28'h0000080, 28'h0000090);
    end

    // Slow memory while the requester's address wanders.
    mem_lat   = 5;
    D_ADDRESS = 28'h0000030;
    D_READ    = 1'b1;
    rd_hi     = 0;
    @(posedge CLK);
    #2;
    tog_en = 1'b1;
    wait_done(1'b1, cyc);
    tog_en = 1'b0;
    mem_lat = 0;
    chk_i("slow_busy_edges", cyc, 7);
    chk_i("slow_strobe_cycles", rd_hi, 7);
    chk_w("slow_read_data", D_READDATA, {4{32'hA5A50030}});

    // Reset in the middle of a D access.
    D_ADDRESS = 28'h0000050;
    D_READ    = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    chk_b("midrst_mem_read", MEM_READ, 1'b0);
    chk_b("midrst_mem_write", MEM_WRITE, 1'b0);
    D_READ = 1'b0;
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    @(negedge CLK);
    chk_w("midrst_d_readdata", D_READDATA, '0);
    chk_i("midrst_mem_address", int'(MEM_ADDRESS), 0);
    @(posedge CLK);
    #2;
    tie_round(28'h00000A0, 28'h00000B0);

    // Read and write together behaves as a write.
    D_ADDRESS   = 28'h0000060;
    D_WRITEDATA = 128'h11112222_33334444_55556666_77778888;
    D_READ      = 1'b1;
    D_WRITE     = 1'b1;
    rd_hi       = 0;
    wr_hi       = 0;
    wait_done(1'b1, cyc);
    chk_i("rw_no_read", rd_hi, 0);
    chk_i("rw_write_cycles", wr_hi, 2);
    D_READ = 1'b1;
    wait_done(1'b1, cyc);
    chk_w("rw_readback", D_READDATA, 128'h11112222_33334444_55556666_77778888);

    // Randomized traffic from both requesters with varying memory latency.
    repeat (3000) begin
      @(negedge CLK);
      acc_i = I_READ && !I_BUSYWAIT;
      acc_d = (D_READ || D_WRITE) && !D_BUSYWAIT;
      @(posedge CLK);
      #2;
      if (!MEM_READ && !MEM_WRITE) mem_lat = $urandom_range(0, 3);
      if (acc_i) begin
        I_READ = 1'b0;
      end else if (!I_READ && $urandom_range(0, 2) == 0) begin
        I_ADDRESS = {20'h0, 4'($urandom_range(0, 15)), 4'h0};
        I_READ    = 1'b1;
      end
      if (acc_d) begin
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
      end else if (!D_READ && !D_WRITE && $urandom_range(0, 2) == 0) begin
        op          = $urandom_range(0, 3);
        D_ADDRESS   = {20'h0, 4'($urandom_range(0, 15)), 4'h0};
        D_WRITEDATA = {$urandom(), $urandom(), $urandom(), $urandom()};
        D_READ      = (op != 2);
        D_WRITE     = (op >= 2);
      end
    end
    I_READ  = 1'b0;
    D_READ  = 1'b0;
    D_WRITE = 1'b0;
    repeat (20) @(posedge CLK);
    chk_b("final_idle_read", MEM_READ, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
